// File: rtl/ram_pkg.sv
// ram_pkg: shared state encoding and constants for the RAM responder.
package ram_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} ramState_t;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/ram_responder_if.sv
// ram_responder_if: memory-control request bus between controller (master) and RAM (slave).
interface ram_responder_if;
  logic        Ren;
  logic        Wen;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        busy_o;
  modport master(output Ren, Wen, ramaddr, ramstore, input ramload, busy_o);
  modport slave(input Ren, Wen, ramaddr, ramstore, output ramload, busy_o);
endinterface

// File: rtl/ram_array.sv
// ram_array: single-port synchronous word memory with registered read.
module ram_array #(
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic               re,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);
  logic [31:0] mem [2**DEPTH_W];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/ram_responder.sv
// ram_responder: wait-state RAM model answering the memory-control request bus.
module ram_responder
  import ram_pkg::*;
#(
  parameter int LAT     = 2,
  parameter int DEPTH_W = 10
) (
  input logic            CLK,
  input logic            RST,
  ram_responder_if.slave bus
);
  ramState_t          state;
  logic [3:0]         cnt;
  logic [DEPTH_W-1:0] idx;
  logic [31:0]        data;
  logic               op_wr;
  logic [31:0]        rdata;
  logic               req;
  logic               fire;
  assign req  = bus.Ren | bus.Wen;
  // The access completes on this edge; reset at the same edge drops it.
  assign fire = state == WAIT && req && cnt == 4'd0 && !RST;
  ram_array #(.DEPTH_W(DEPTH_W)) u_array (
    .clk  (CLK),
    .we   (fire && op_wr),
    .re   (fire && !op_wr),
    .addr (idx),
    .wdata(data),
    .rdata(rdata)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: if (req) begin
          state <= WAIT;
          cnt   <= 4'(LAT - 1);
          idx   <= DEPTH_W'(bus.ramaddr >> $clog2(WORD_BYTES));
          data  <= bus.ramstore;
          op_wr <= bus.Wen;
        end
        WAIT: begin
          if (!req) state <= IDLE;
          else if (cnt == 4'd0) state <= DONE;
          else cnt <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.busy_o  = (state == IDLE && req) || state == WAIT;
  assign bus.ramload = (state == DONE && !op_wr) ? rdata : '0;
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed self-checking bench for ram_responder with LAT=2, DEPTH_W=10.
module tb_ram_responder;
  import ram_pkg::*;
  localparam int LAT = 2;
  logic clk = 0;
  logic rst = 0;
  int checks = 0;
  int errors = 0;
  ram_responder_if bus();
  ram_responder #(.LAT(LAT), .DEPTH_W(10)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // One complete access: busy for cycles 0..LAT, DONE with exp_load in cycle LAT+1.
  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_load, input string tag);
    @(posedge clk); #1;
    bus.Wen = w; bus.Ren = r; bus.ramaddr = a; bus.ramstore = d;
    for (int i = 0; i <= LAT; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
      chk({tag, "_load0"}, bus.ramload, 32'd0);
    end
    @(negedge clk);
    chk({tag, "_done_busy"}, 32'(bus.busy_o), 32'd0);
    chk({tag, "_done_state"}, 32'(dut.state), 32'(DONE));
    chk({tag, "_load"}, bus.ramload, exp_load);
    bus.Wen = 0; bus.Ren = 0;
  endtask
  initial begin
    bus.Ren = 0; bus.Wen = 0; bus.ramaddr = 0; bus.ramstore = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_busy", 32'(bus.busy_o), 32'd0);
    chk("reset_load", bus.ramload, 32'd0);
    chk("reset_state", 32'(dut.state), 32'(IDLE));
    access(1, 0, 32'h10, 32'hDEADBEEF, 32'h0, "wr10");
    access(0, 1, 32'h10, 32'h0, 32'hDEADBEEF, "rd10");
    access(1, 0, 32'h13, 32'h12345678, 32'h0, "wr13");
    access(0, 1, 32'h10, 32'h0, 32'h12345678, "rd_alias");
    access(0, 1, 32'h1010, 32'h0, 32'h12345678, "rd_wrap");
    access(1, 0, 32'h20, 32'h1, 32'h0, "wr20");
    @(posedge clk); #1;
    bus.Wen = 1; bus.ramaddr = 32'h20; bus.ramstore = 32'hAAAA0000;
    @(negedge clk);
    chk("abort_busy0", 32'(bus.busy_o), 32'd1);
    @(negedge clk);
    chk("abort_wait", 32'(dut.state), 32'(WAIT));
    bus.Wen = 0;
    @(negedge clk);
    chk("abort_idle", 32'(dut.state), 32'(IDLE));
    chk("abort_busy", 32'(bus.busy_o), 32'd0);
    access(0, 1, 32'h20, 32'h0, 32'h1, "rd_abort");
    access(1, 1, 32'h30, 32'h55, 32'h0, "both");
    access(0, 1, 32'h30, 32'h0, 32'h55, "rd_both");
    access(1, 0, 32'h40, 32'h9, 32'h0, "wr40");
    @(posedge clk); #1;
    bus.Wen = 1; bus.ramaddr = 32'h40; bus.ramstore = 32'h77;
    @(negedge clk);
    chk("rstw_busy0", 32'(bus.busy_o), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("rstw_wait_last", 32'(dut.state), 32'(WAIT));
    rst = 1;
    @(negedge clk);
    chk("rstw_idle", 32'(dut.state), 32'(IDLE));
    chk("rstw_busy_req", 32'(bus.busy_o), 32'd1);
    chk("rstw_load", bus.ramload, 32'd0);
    rst = 0; bus.Wen = 0;
    @(negedge clk);
    chk("rstw_busy_idle", 32'(bus.busy_o), 32'd0);
    access(0, 1, 32'h40, 32'h0, 32'h9, "rd_rstw");
    access(0, 1, 32'h13, 32'h0, 32'h12345678, "rd13");
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_responder.md
# ram_responder

Single-port word RAM model that sits on the far side of the memory-control request bus and answers its `Ren`/`Wen`/`ramaddr`/`ramstore` requests with `ramload` and `busy_o`. It inserts a programmable wait-state latency so the memory controller's stall handling is exercised. It is the simulation and FPGA backing store for the core's instruction and data traffic, instantiated next to the memory controller at the top level.

## Interface
Parameters:
- `LAT`, 2: wait states per access; legal range is 1 to 15.
- `DEPTH_W`, 10: log2 of the number of 32-bit words.

Ports:
- `CLK` in 1: the single clock; everything is on the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `Ren` in 1: read request, level.
- `Wen` in 1: write request, level.
- `ramaddr` in 32: byte address.
- `ramstore` in 32: write data.
- `ramload` out 32: read data; valid only in `DONE`.
- `busy_o` out 1: request pending and not complete.

## Operation
- Word index is `ramaddr[DEPTH_W+1:2]`.
  - Bits [1:0] are ignored, so misaligned addresses round down.
  - Upper bits are ignored, so addresses wrap modulo 4·2^DEPTH_W bytes.
- FSM states: `IDLE`, `WAIT`, `DONE`.
- `IDLE`:
  - With `Ren|Wen` = 1, latch the word index, `ramstore` and the op (write if `Wen`, else read), load `cnt` ← `LAT-1`, then go to `WAIT`.
  - Otherwise stay in `IDLE`.
- `WAIT`:
  - If `Ren|Wen` = 0 (request withdrawn), go to `IDLE`. The access is aborted and no write occurs.
  - Else if `cnt` = 0: go to `DONE`. On this edge a write commits `mem[idx]` ← latched data, and a read registers `mem[idx]` into the `ramload` register.
  - Else `cnt` ← `cnt`-1.
- `DONE`: go to `IDLE` on the next edge, unconditionally.
  - A request still asserted in `DONE` is treated as a new request, accepted from `IDLE` one cycle later.
- Outputs:
  - `busy_o` = (`IDLE` and (`Ren|Wen`)) or `WAIT`. This is combinational, so the initiator sees a stall in the same cycle it raises a request.
  - `busy_o` = 0 in `DONE`.
  - `ramload` = registered read data in `DONE`, 0 in every other state. After a write, `ramload` in `DONE` is 0.
- Simultaneous `Ren` and `Wen`: `Wen` wins; the access is a write.
- Changes to `ramaddr`/`ramstore` during `WAIT` are ignored; the latched values are used. The initiator is required to hold them steady.

## Timing
- A request first asserted in cycle 0 (state `IDLE`):
  - `busy_o` = 1 in cycles 0 to `LAT`.
  - `DONE` and `busy_o` = 0 in cycle `LAT`+1.
  - Read data is valid in cycle `LAT`+1.
  - A write is visible to a read that completes in cycle 2·`LAT`+3 or later.
- Back-to-back requests held continuously complete every `LAT`+2 cycles.
- Reset (`RST` = 1 at an edge) forces `IDLE`, `cnt` = 0, `ramload` = 0 and `busy_o` = combinational from inputs. This applies mid-`WAIT` as well: a pending write is dropped.
- Memory contents are not reset and are undefined until written.

## Structure
- Package `ram_pkg`:
  - state enum `ramState_t` {`IDLE`, `WAIT`, `DONE`}.
  - constant `WORD_BYTES` = 4.
- Sub-module `ram_array`: single-port synchronous word memory, 2^DEPTH_W × 32, with one write enable and a registered read. `ram_responder` holds the FSM, counter, request latches and output muxing.

## Test plan
- Reset then idle: `RST` = 1 for 2 cycles, inputs 0 → `busy_o` = 0, `ramload` = 0, state `IDLE`.
- Write then read, `LAT` = 2:
  - `Wen`, `ramaddr` = 0x10, `ramstore` = 0xDEADBEEF held until `busy_o` drops → `busy_o` = 1 for 3 cycles, then 0 for one cycle.
  - Then `Ren` at 0x10 → `ramload` = 0xDEADBEEF in cycle 3 of the read.
- Aliasing, `DEPTH_W` = 10:
  - Write 0x12345678 to 0x13 → a read of 0x10 returns 0x12345678.
  - A read of 0x1010 also returns 0x12345678 (wrap).
- Abort: `Wen` to 0x20 with 0xAAAA0000, deasserted in the first `WAIT` cycle; previous contents 0x1 → `FSM` in `IDLE` next cycle, and a later read of 0x20 returns 0x1.
- Both `Ren` and `Wen` to 0x30 with `ramstore` = 0x55 → treated as a write: `ramload` = 0 in `DONE`, and a later read returns 0x55.
- Reset mid-`WAIT`: write 0x77 to 0x40 over old value 0x9, with `RST` pulsed in `WAIT` → a subsequent read of 0x40 returns 0x9, and `busy_o` tracks the new request correctly.
